// File: rtl/fetch_queue_if.sv
// Cache-request / decoder-issue bundle around the fetch queue; slave is the queue side,
// master is the environment (cache, decoder, RoB) driving it.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   rdy;
  logic                   rob_clear;
  logic [ADDR_WIDTH-1:0]  back_pc;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   start_fetch;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   instr_ready_in;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [ADDR_WIDTH-1:0]  instr_addr_in;
  logic                   instr_issued;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  instr_addr;

  modport slave (
    input  rdy, rob_clear, back_pc, redirect_valid, redirect_pc,
    input  instr_ready_in, instr_in, instr_addr_in, instr_issued,
    output start_fetch, pc, instr_ready, instr, instr_addr
  );

  modport master (
    output rdy, rob_clear, back_pc, redirect_valid, redirect_pc,
    output instr_ready_in, instr_in, instr_addr_in, instr_issued,
    input  start_fetch, pc, instr_ready, instr, instr_addr
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential prefetch FIFO between icache and decoder; a response lands at the head one edge after acceptance.
// Fetching pauses only while the FIFO is full; flushes drop stale responses by matching against pc.
module fetch_queue #(
  parameter int                    DEPTH       = 4,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);

  logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_mem_addr  [DEPTH];
  logic [PW-1:0]          r_head, r_tail;
  logic [PW:0]            r_count;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_start_fetch;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_instr_addr;

  logic                   w_flush, w_push, w_pop;
  logic [PW:0]            w_count_next, w_remain;
  logic [PW-1:0]          w_head_next;
  logic [INSTR_WIDTH-1:0] w_head_instr;
  logic [ADDR_WIDTH-1:0]  w_head_addr;

  assign w_flush = bus.rob_clear | bus.redirect_valid;
  // A response only counts if it answers the current request; anything else is pre-flush traffic.
  assign w_push  = bus.instr_ready_in & r_start_fetch & (bus.instr_addr_in == r_pc) & ~w_flush;
  assign w_pop   = bus.instr_issued & (r_count != '0) & ~w_flush;

  assign w_count_next = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_remain     = r_count - (PW+1)'(w_pop);
  assign w_head_next  = r_head + PW'(w_pop);

  // Head output is registered, so pre-compute what sits at the head after this edge.
  always_comb begin
    w_head_instr = r_mem_instr[w_head_next];
    w_head_addr  = r_mem_addr[w_head_next];
    if (w_remain == '0) begin
      w_head_instr = w_push ? bus.instr_in      : '0;
      w_head_addr  = w_push ? bus.instr_addr_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rdy && w_push) begin
      r_mem_instr[r_tail] <= bus.instr_in;
      r_mem_addr[r_tail]  <= bus.instr_addr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_pc          <= RESET_PC;
      r_start_fetch <= 1'b1;
      r_instr       <= '0;
      r_instr_addr  <= '0;
    end else if (bus.rdy) begin
      if (w_flush) begin
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_pc          <= bus.rob_clear ? bus.back_pc : bus.redirect_pc;
        r_start_fetch <= 1'b1;
        r_instr       <= '0;
        r_instr_addr  <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + PW'(1);
          r_pc   <= r_pc + ADDR_WIDTH'(4);
        end
        r_head        <= w_head_next;
        r_count       <= w_count_next;
        r_start_fetch <= (w_count_next < (PW+1)'(DEPTH));
        r_instr       <= w_head_instr;
        r_instr_addr  <= w_head_addr;
      end
    end
  end

  assign bus.start_fetch = r_start_fetch;
  assign bus.pc          = r_pc;
  assign bus.instr_ready = (r_count != '0);
  assign bus.instr       = r_instr;
  assign bus.instr_addr  = r_instr_addr;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue (DEPTH=4, RESET_PC=0) plus an async-reset sequence.
module tb_fetch_queue;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_queue #(
    .DEPTH(4), .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rc;
    logic [31:0] bpc;
    logic        rv;
    logic [31:0] rpc;
    logic        rsp;
    logic [31:0] raddr;
    logic        iss;
    logic        e_sf;
    logic [31:0] e_pc;
    logic        e_rdy;
    logic [31:0] e_addr;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic rc, logic [31:0] bpc, logic rv, logic [31:0] rpc,
                              logic rsp, logic [31:0] raddr, logic iss, logic e_sf,
                              logic [31:0] e_pc, logic e_rdy, logic [31:0] e_addr, int e_cnt);
    vec_t v;
    v.rdy = rdy; v.rc = rc; v.bpc = bpc; v.rv = rv; v.rpc = rpc;
    v.rsp = rsp; v.raddr = raddr; v.iss = iss; v.e_sf = e_sf;
    v.e_pc = e_pc; v.e_rdy = e_rdy; v.e_addr = e_addr; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic logic [31:0] mk_instr(logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rdy, logic rc, logic [31:0] bpc, logic rv, logic [31:0] rpc,
                       logic rsp, logic [31:0] raddr, logic iss);
    bus.rdy            = rdy;
    bus.rob_clear      = rc;
    bus.back_pc        = bpc;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.instr_ready_in = rsp;
    bus.instr_addr_in  = raddr;
    bus.instr_in       = mk_instr(raddr);
    bus.instr_issued   = iss;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(string tag, logic e_sf, logic [31:0] e_pc, logic e_rdy,
                           logic [31:0] e_addr, int e_cnt);
    chk({tag, ".start_fetch"}, 64'(bus.start_fetch), 64'(e_sf));
    chk({tag, ".pc"},          64'(bus.pc),          64'(e_pc));
    chk({tag, ".instr_ready"}, 64'(bus.instr_ready), 64'(e_rdy));
    chk({tag, ".count"},       64'(dut.r_count),     64'(e_cnt));
    if (e_rdy) begin
      chk({tag, ".instr_addr"}, 64'(bus.instr_addr), 64'(e_addr));
      chk({tag, ".instr"},      64'(bus.instr),      64'(mk_instr(e_addr)));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // rdy rc bpc rv rpc | rsp raddr iss | start pc ready head_addr count
    vecs.push_back(mk(1,0,0,0,0, 1,32'h00,0, 1,32'h04,1,32'h00,1));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h04,0, 1,32'h08,1,32'h00,2));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h08,0, 1,32'h0C,1,32'h00,3));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h0C,0, 0,32'h10,1,32'h00,4));
    vecs.push_back(mk(1,0,0,0,0, 0,32'h00,0, 0,32'h10,1,32'h00,4));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h10,0, 0,32'h10,1,32'h00,4));
    vecs.push_back(mk(1,0,0,0,0, 0,32'h00,1, 1,32'h10,1,32'h04,3));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h10,1, 1,32'h14,1,32'h08,3));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h14,0, 0,32'h18,1,32'h08,4));
    vecs.push_back(mk(1,0,0,0,0, 0,32'h00,1, 1,32'h18,1,32'h0C,3));
    vecs.push_back(mk(1,0,0,0,0, 0,32'h00,1, 1,32'h18,1,32'h10,2));
    vecs.push_back(mk(1,0,0,0,0, 0,32'h00,1, 1,32'h18,1,32'h14,1));
    vecs.push_back(mk(1,0,0,0,0, 0,32'h00,1, 1,32'h18,0,32'h00,0));
    vecs.push_back(mk(1,0,0,0,0, 0,32'h00,1, 1,32'h18,0,32'h00,0));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h30,0, 1,32'h18,0,32'h00,0));
    vecs.push_back(mk(1,1,32'h200,0,0, 1,32'h18,1, 1,32'h200,0,32'h00,0));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h18,0, 1,32'h200,0,32'h00,0));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h200,0, 1,32'h204,1,32'h200,1));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h204,0, 1,32'h208,1,32'h200,2));
    vecs.push_back(mk(1,0,0,1,32'h80, 0,32'h00,1, 1,32'h80,0,32'h00,0));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h80,0, 1,32'h84,1,32'h80,1));
    vecs.push_back(mk(1,1,32'h40,1,32'h80, 0,32'h00,0, 1,32'h40,0,32'h00,0));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h40,0, 1,32'h44,1,32'h40,1));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h44,1, 1,32'h44,1,32'h40,1));
    vecs.push_back(mk(0,1,32'h300,0,0, 0,32'h00,1, 1,32'h44,1,32'h40,1));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h44,0, 1,32'h44,1,32'h40,1));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h44,1, 1,32'h48,1,32'h44,1));

    #12;
    chk_state("reset", 1'b1, 32'h0, 1'b0, 32'h0, 0);
    chk("reset.instr",      64'(bus.instr),      64'h0);
    chk("reset.instr_addr", 64'(bus.instr_addr), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rdy, vecs[i].rc, vecs[i].bpc, vecs[i].rv, vecs[i].rpc,
            vecs[i].rsp, vecs[i].raddr, vecs[i].iss);
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].e_sf, vecs[i].e_pc, vecs[i].e_rdy,
                vecs[i].e_addr, vecs[i].e_cnt);
      if (vecs[i].rc || vecs[i].rv) begin
        if (vecs[i].rdy) begin
          chk($sformatf("vec%0d.flush_addr", i),  64'(bus.instr_addr), 64'h0);
          chk($sformatf("vec%0d.flush_instr", i), 64'(bus.instr),      64'h0);
        end
      end
    end

    // Asynchronous reset between edges, with a request outstanding.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 1'b1, 32'h0, 1'b0, 32'h0, 0);
    chk("async_rst.instr",      64'(bus.instr),      64'h0);
    chk("async_rst.instr_addr", 64'(bus.instr_addr), 64'h0);
    #2;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 32'h48, 0);
    tick();
    chk_state("post_rst_stale", 1'b1, 32'h0, 1'b0, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h00, 0);
    tick();
    chk_state("post_rst_accept", 1'b1, 32'h4, 1'b1, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
